// File: rtl/pq_rf_dma_pkg.sv
// Shared types and constants for the PQ register-file DMA engine.
package pq_dma_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int   WORD_BYTES = 4;
   localparam logic DIR_LOAD   = 1'b0;
   localparam logic DIR_STORE  = 1'b1;

endpackage

// File: rtl/pq_rf_dma.sv
// Word-transfer engine between core data memory and the PQ register file.
// One OBI-style transaction outstanding at a time; load fills RF entries,
// store drains them back to memory.
module pq_rf_dma
   import pq_dma_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_AW     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic                  dir_i,
   input  logic [MEM_AW-1:0]     base_addr_i,
   input  logic [ADDR_WIDTH-1:0] rf_start_i,
   input  logic [ADDR_WIDTH:0]   num_words_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic                  data_req_o,
   input  logic                  data_gnt_i,
   output logic [MEM_AW-1:0]     data_addr_o,
   output logic                  data_we_o,
   output logic [3:0]            data_be_o,
   output logic [DATA_WIDTH-1:0] data_wdata_o,
   input  logic                  data_rvalid_i,
   input  logic [DATA_WIDTH-1:0] data_rdata_i,
   input  logic                  data_err_i,
   output logic                  rf_we_o,
   output logic [ADDR_WIDTH-1:0] rf_waddr_o,
   output logic [DATA_WIDTH-1:0] rf_wdata_o,
   output logic [ADDR_WIDTH-1:0] rf_raddr_o,
   input  logic [DATA_WIDTH-1:0] rf_rdata_i
);

   localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] ONE_WORD  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [MEM_AW-1:0]   ADDR_STEP = MEM_AW'(WORD_BYTES);

   state_t                  state;
   state_t                  state_nx;
   logic                    dir;
   logic [MEM_AW-1:0]       addr;
   logic [ADDR_WIDTH-1:0]   idx;
   logic [ADDR_WIDTH:0]     remaining;
   logic                    err;
   logic                    rf_we;
   logic [ADDR_WIDTH-1:0]   rf_waddr;
   logic [DATA_WIDTH-1:0]   rf_wdata;

   logic                    accept;
   logic                    resp;
   logic                    last;
   logic [ADDR_WIDTH:0]     count_sat;

   assign accept    = (state == S_IDLE) && start_i;
   assign resp      = (state == S_WAIT) && data_rvalid_i;
   assign last      = (remaining == ONE_WORD);
   // Oversized requests are clipped to the whole register file.
   assign count_sat = (num_words_i > MAX_WORDS) ? MAX_WORDS : num_words_i;

   // State register; reset aborts any command in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode and state-derived handshake/status outputs.
   always_comb begin
      state_nx   = state;
      data_req_o = 1'b0;
      data_we_o  = 1'b0;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_i) begin
               state_nx = (count_sat == '0) ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            data_req_o = 1'b1;
            data_we_o  = (dir == DIR_STORE);
            busy_o     = 1'b1;
            if (data_gnt_i) begin
               state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            busy_o = 1'b1;
            if (data_rvalid_i) begin
               state_nx = (data_err_i || last) ? S_DONE : S_REQ;
            end
         end
         S_DONE: begin
            done_o   = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Command latch, per-word address/index advance, sticky error and RF write pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir       <= DIR_LOAD;
         addr      <= '0;
         idx       <= '0;
         remaining <= '0;
         err       <= 1'b0;
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
      end else begin
         rf_we <= 1'b0;
         if (accept) begin
            dir       <= dir_i;
            addr      <= base_addr_i;
            idx       <= rf_start_i;
            remaining <= count_sat;
            err       <= 1'b0;
         end else if (resp) begin
            if (data_err_i) begin
               err <= 1'b1;
            end else begin
               // Load data lands in the RF one cycle after the response.
               if (dir == DIR_LOAD) begin
                  rf_we    <= 1'b1;
                  rf_waddr <= idx;
                  rf_wdata <= data_rdata_i;
               end
               addr      <= addr + ADDR_STEP;
               idx       <= idx + 1'b1;
               remaining <= remaining - ONE_WORD;
            end
         end
      end
   end

   assign data_addr_o  = addr;
   assign data_be_o    = 4'hF;
   // Store data comes straight from the RF read port addressed by the current index.
   assign data_wdata_o = (dir == DIR_STORE) ? rf_rdata_i : '0;
   assign err_o        = err;
   assign rf_we_o      = rf_we;
   assign rf_waddr_o   = rf_waddr;
   assign rf_wdata_o   = rf_wdata;
   assign rf_raddr_o   = idx;

endmodule

// File: tb/tb_pq_rf_dma.sv
// Bench for pq_rf_dma: command table plus a memory/RF model with scoreboards.
module tb_pq_rf_dma;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic        dir_i;
   logic [31:0] base_addr_i;
   logic [4:0]  rf_start_i;
   logic [5:0]  num_words_i;
   logic        busy_o, done_o, err_o;
   logic        data_req_o, data_gnt_i, data_we_o;
   logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
   logic [3:0]  data_be_o;
   logic        data_rvalid_i, data_err_i;
   logic        rf_we_o;
   logic [4:0]  rf_waddr_o, rf_raddr_o;
   logic [31:0] rf_wdata_o, rf_rdata_i;

   logic        mem_gnt, mem_rvalid, mem_err, extra_rvalid;
   logic [31:0] mem_rdata;
   logic [31:0] rf_mem [32];

   logic [31:0] cur_base;
   int          cur_delay;
   int          cur_err_at;

   int checks;
   int failures;

   typedef struct {
      logic        dir;
      logic [31:0] base;
      logic [4:0]  rs;
      logic [5:0]  num;
      int          delay;
      int          err_at;
      int          mid;
      int          exp_done;
      logic        exp_err;
   } cmd_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] data;
   } bus_t;

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] data;
   } rfw_t;

   bus_t exp_bus[$];
   rfw_t exp_rf[$];
   cmd_t tbl[8];

   assign data_gnt_i    = mem_gnt;
   assign data_rvalid_i = mem_rvalid | extra_rvalid;
   assign data_rdata_i  = mem_rdata;
   assign data_err_i    = mem_err;
   assign rf_rdata_i    = rf_mem[rf_raddr_o];

   pq_rf_dma #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .MEM_AW(32)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .dir_i(dir_i),
      .base_addr_i(base_addr_i), .rf_start_i(rf_start_i), .num_words_i(num_words_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
      .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
      .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
      .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] idle_outputs();
      return 128'({busy_o, done_o, err_o, data_req_o, data_we_o, data_addr_o,
                   data_wdata_o, rf_we_o, rf_waddr_o, rf_wdata_o, rf_raddr_o});
   endfunction

   // Memory slave and RF model: grants after cur_delay stall cycles, answers one cycle after grant.
   initial begin : mem_model
      logic         hs_prev;
      int           k_prev;
      int           stall;
      logic [64:0]  snap;
      bus_t         eb;
      rfw_t         er;
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'(i);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
      hs_prev = 1'b0; k_prev = 0; stall = 0; snap = '0;
      forever begin
         @(negedge clk);
         mem_rvalid = hs_prev;
         mem_rdata  = hs_prev ? (32'h00010002 + 32'(k_prev)) : 32'h0;
         mem_err    = hs_prev && ((k_prev + 1) == cur_err_at);
         hs_prev    = 1'b0;
         if (rf_we_o) begin
            chk("rf_write_expected", 128'(exp_rf.size() > 0), 128'(1));
            if (exp_rf.size() > 0) begin
               er = exp_rf.pop_front();
               chk("rf_write", 128'({rf_waddr_o, rf_wdata_o}), 128'({er.idx, er.data}));
               rf_mem[er.idx] = er.data;
            end
         end
         mem_gnt = 1'b0;
         if (data_req_o && rst_n) begin
            if (stall == 0) snap = {data_addr_o, data_we_o, data_wdata_o};
            else chk("req_stable", 128'({data_addr_o, data_we_o, data_wdata_o}), 128'(snap));
            if (stall == cur_delay) begin
               mem_gnt = 1'b1;
               stall   = 0;
               hs_prev = 1'b1;
               k_prev  = int'((data_addr_o - cur_base) >> 2);
               chk("req_expected", 128'(exp_bus.size() > 0), 128'(1));
               if (exp_bus.size() > 0) begin
                  eb = exp_bus.pop_front();
                  if (eb.we)
                     chk("req_fields", 128'({data_addr_o, data_we_o, data_wdata_o}),
                         128'({eb.addr, eb.we, eb.data}));
                  else
                     chk("req_fields", 128'({data_addr_o, data_we_o}), 128'({eb.addr, eb.we}));
               end
            end else begin
               stall++;
            end
         end else begin
            stall = 0;
         end
      end
   end

   task automatic run_cmd(input cmd_t c, input logic prev_err);
      int         nsat, nbus, nrf, cyc, done_cyc;
      logic [4:0] ix;
      bus_t       b;
      rfw_t       r;
      nsat = (int'(c.num) > 32) ? 32 : int'(c.num);
      nbus = (c.err_at != 0) ? c.err_at : nsat;
      nrf  = c.dir ? 0 : ((c.err_at != 0) ? c.err_at - 1 : nsat);
      cur_base = c.base; cur_delay = c.delay; cur_err_at = c.err_at;
      for (int j = 0; j < nbus; j++) begin
         ix     = c.rs + 5'(j);
         b.addr = c.base + 32'(4 * j);
         b.we   = c.dir;
         b.data = c.dir ? rf_mem[ix] : 32'h0;
         exp_bus.push_back(b);
      end
      for (int j = 0; j < nrf; j++) begin
         r.idx  = c.rs + 5'(j);
         r.data = 32'h00010002 + 32'(j);
         exp_rf.push_back(r);
      end
      chk("err_sticky", 128'(err_o), 128'(prev_err));
      dir_i = c.dir; base_addr_i = c.base; rf_start_i = c.rs; num_words_i = c.num;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      cyc = 1;
      chk("busy_after_start", 128'({busy_o, err_o}), 128'({nsat != 0, 1'b0}));
      done_cyc = -1;
      while (cyc < 400) begin
         if (c.mid != 0 && cyc == c.mid) begin
            start_i = 1'b1; dir_i = ~c.dir; num_words_i = 6'd1;
            rf_start_i = 5'd20; base_addr_i = 32'h9990;
         end else begin
            start_i = 1'b0;
         end
         if (done_o) begin
            done_cyc = cyc;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      start_i = 1'b0;
      chk("done_cycle", 128'(done_cyc), 128'(c.exp_done));
      chk("done_status", 128'({busy_o, err_o, rf_we_o}),
          128'({1'b0, c.exp_err, (!c.dir && c.err_at == 0 && nsat > 0)}));
      @(negedge clk);
      chk("done_pulse_end", 128'({done_o, busy_o}), 128'(0));
      chk("queues_drained", 128'({exp_bus.size() == 0, exp_rf.size() == 0}), 128'(2'b11));
   endtask

   initial begin : main
      cmd_t       rc;
      logic       prev_err;
      checks = 0; failures = 0;
      rst_n = 1'b0; start_i = 1'b0; dir_i = 1'b0; base_addr_i = '0;
      rf_start_i = '0; num_words_i = '0; extra_rvalid = 1'b0;
      cur_base = '0; cur_delay = 0; cur_err_at = 0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", idle_outputs(), 128'(0));
      chk("byte_enables", 128'(data_be_o), 128'(4'hF));
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", idle_outputs(), 128'(0));

      //           dir   base           rs     num    dly err mid done err
      tbl[0] = '{1'b1, 32'h0000_0200, 5'd5,  6'd32, 2,  0,  0,  129, 1'b0};
      tbl[1] = '{1'b0, 32'h0000_0100, 5'd0,  6'd4,  0,  0,  0,  9,   1'b0};
      tbl[2] = '{1'b0, 32'h0000_0300, 5'd10, 6'd3,  0,  2,  0,  5,   1'b1};
      tbl[3] = '{1'b0, 32'h0000_0500, 5'd0,  6'd0,  0,  0,  0,  1,   1'b0};
      tbl[4] = '{1'b0, 32'h0000_0400, 5'd0,  6'd33, 0,  0,  0,  65,  1'b0};
      tbl[5] = '{1'b0, 32'h0000_1000, 5'd7,  6'd63, 1,  0,  0,  97,  1'b0};
      tbl[6] = '{1'b0, 32'h0000_0600, 5'd3,  6'd5,  0,  0,  4,  11,  1'b0};
      tbl[7] = '{1'b1, 32'hFFFF_FFFC, 5'd31, 6'd2,  1,  0,  0,  7,   1'b0};

      prev_err = 1'b0;
      for (int t = 0; t < 8; t++) begin
         run_cmd(tbl[t], prev_err);
         prev_err = tbl[t].exp_err;
      end

      // Reset while waiting for a response, then a stray rvalid after release.
      rc = '{1'b0, 32'h0000_0700, 5'd0, 6'd4, 0, 0, 0, 0, 1'b0};
      cur_base = rc.base; cur_delay = 0; cur_err_at = 0;
      exp_bus.push_back('{32'h0000_0700, 1'b0, 32'h0});
      dir_i = rc.dir; base_addr_i = rc.base; rf_start_i = rc.rs; num_words_i = rc.num;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      chk("in_wait", 128'({busy_o, data_req_o}), 128'(2'b10));
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_outputs", idle_outputs(), 128'(0));
      rst_n = 1'b1;
      @(negedge clk);
      extra_rvalid = 1'b1;
      @(negedge clk);
      extra_rvalid = 1'b0;
      chk("stray_rvalid_ignored", idle_outputs(), 128'(0));
      repeat (4) @(negedge clk);
      chk("stays_idle", idle_outputs(), 128'(0));
      chk("abort_queues", 128'({exp_bus.size() == 0, exp_rf.size() == 0}), 128'(2'b11));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
